// File: rtl/dsp_mac_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dsp_mac_acc
// Description : Pipelined signed multiply-accumulate with chain framing.
//               Each accepted beat forms A*B and applies it to the
//               accumulator (load / add / subtract / C-plus-product).
//               Overflow either saturates or wraps. A LAST beat emits the
//               chain result with its sticky overflow flag and beat count.
//               Backpressure from OUT_READY stalls the whole pipeline.
// Ports       : CLK, RSTB (async, active-high)
//               IN_VALID/IN_READY, A, B, C, OPM, LAST  - input beat
//               OUT_VALID/OUT_READY, P, OVF, CNT       - chain result
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_acc #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter int MDEPTH = 2,
    parameter int SAT_EN = 1,
    parameter int CW     = 16
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    input  logic [PW-1:0] C,
    input  logic [1:0]    OPM,
    input  logic          LAST,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [PW-1:0] P,
    output logic          OVF,
    output logic [CW-1:0] CNT
);

    localparam logic [PW-1:0] c_pmax = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] c_pmin = {1'b1, {(PW-1){1'b0}}};
    localparam logic [1:0]    c_op_load = 2'b00;
    localparam logic [1:0]    c_op_add  = 2'b01;
    localparam logic [1:0]    c_op_sub  = 2'b10;

    // Input register stage
    logic          in_vld_q,  in_vld_d;
    logic [AW-1:0] in_a_q,    in_a_d;
    logic [BW-1:0] in_b_q,    in_b_d;
    logic [PW-1:0] in_c_q,    in_c_d;
    logic [1:0]    in_opm_q,  in_opm_d;
    logic          in_last_q, in_last_d;

    // Product register stages; index MDEPTH-1 feeds the accumulator
    logic          pr_vld_q  [MDEPTH];
    logic          pr_vld_d  [MDEPTH];
    logic [PW-1:0] pr_prod_q [MDEPTH];
    logic [PW-1:0] pr_prod_d [MDEPTH];
    logic [PW-1:0] pr_c_q    [MDEPTH];
    logic [PW-1:0] pr_c_d    [MDEPTH];
    logic [1:0]    pr_opm_q  [MDEPTH];
    logic [1:0]    pr_opm_d  [MDEPTH];
    logic          pr_last_q [MDEPTH];
    logic          pr_last_d [MDEPTH];

    // Accumulator, chain state and output register
    logic [PW-1:0] acc_q,       acc_d;
    logic          sticky_q,    sticky_d;
    logic [CW-1:0] count_q,     count_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] p_q,         p_d;
    logic          ovf_q,       ovf_d;
    logic [CW-1:0] cnt_q,       cnt_d;

    logic                 w_adv;
    logic                 w_commit;
    logic [AW+BW-1:0]     w_a_ext;
    logic [AW+BW-1:0]     w_b_ext;
    logic [AW+BW-1:0]     w_mult;
    logic [PW-1:0]        w_prod;
    logic [PW:0]          w_exact;
    logic                 w_bovf;
    logic [PW-1:0]        w_acc_next;
    logic [CW-1:0]        w_cnt_inc;

    // The pipeline advances whenever the output slot is free or draining.
    // Depends only on registered state and OUT_READY, never on IN_VALID.
    assign w_adv    = !out_valid_q || OUT_READY;
    assign w_commit = w_adv && pr_vld_q[MDEPTH-1];
    assign IN_READY = w_adv;

    // Low AW+BW bits of the product of sign-extended operands equal the
    // exact signed product.
    assign w_a_ext = {{BW{in_a_q[AW-1]}}, in_a_q};
    assign w_b_ext = {{AW{in_b_q[BW-1]}}, in_b_q};
    assign w_mult  = w_a_ext * w_b_ext;
    assign w_prod  = {{(PW-AW-BW){w_mult[AW+BW-1]}}, w_mult};

    // One guard bit holds the exact result of a single add/subtract.
    always_comb begin
        w_exact = {pr_prod_q[MDEPTH-1][PW-1], pr_prod_q[MDEPTH-1]};
        case (pr_opm_q[MDEPTH-1])
            c_op_load: w_exact = {pr_prod_q[MDEPTH-1][PW-1], pr_prod_q[MDEPTH-1]};
            c_op_add:  w_exact = {acc_q[PW-1], acc_q}
                               + {pr_prod_q[MDEPTH-1][PW-1], pr_prod_q[MDEPTH-1]};
            c_op_sub:  w_exact = {acc_q[PW-1], acc_q}
                               - {pr_prod_q[MDEPTH-1][PW-1], pr_prod_q[MDEPTH-1]};
            default:   w_exact = {pr_c_q[MDEPTH-1][PW-1], pr_c_q[MDEPTH-1]}
                               + {pr_prod_q[MDEPTH-1][PW-1], pr_prod_q[MDEPTH-1]};
        endcase
    end

    // Result does not fit when the guard bit disagrees with the sign bit
    assign w_bovf = w_exact[PW] ^ w_exact[PW-1];

    always_comb begin
        w_acc_next = w_exact[PW-1:0];
        if (w_bovf && (SAT_EN != 0)) begin
            w_acc_next = w_exact[PW] ? c_pmin : c_pmax;
        end
    end

    assign w_cnt_inc = (&count_q) ? count_q : (count_q + {{(CW-1){1'b0}}, 1'b1});

    always_comb begin
        in_vld_d    = in_vld_q;
        in_a_d      = in_a_q;
        in_b_d      = in_b_q;
        in_c_d      = in_c_q;
        in_opm_d    = in_opm_q;
        in_last_d   = in_last_q;
        pr_vld_d    = pr_vld_q;
        pr_prod_d   = pr_prod_q;
        pr_c_d      = pr_c_q;
        pr_opm_d    = pr_opm_q;
        pr_last_d   = pr_last_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;

        if (w_adv) begin
            // Data fields load every advance; the valid bit marks bubbles.
            in_vld_d  = IN_VALID;
            in_a_d    = A;
            in_b_d    = B;
            in_c_d    = C;
            in_opm_d  = OPM;
            in_last_d = LAST;

            pr_vld_d[0]  = in_vld_q;
            pr_prod_d[0] = w_prod;
            pr_c_d[0]    = in_c_q;
            pr_opm_d[0]  = in_opm_q;
            pr_last_d[0] = in_last_q;
            for (int i = 1; i < MDEPTH; i++) begin
                pr_vld_d[i]  = pr_vld_q[i-1];
                pr_prod_d[i] = pr_prod_q[i-1];
                pr_c_d[i]    = pr_c_q[i-1];
                pr_opm_d[i]  = pr_opm_q[i-1];
                pr_last_d[i] = pr_last_q[i-1];
            end

            // Advancing implies the current result is consumed or absent
            out_valid_d = 1'b0;

            if (w_commit) begin
                acc_d = w_acc_next;
                if (pr_last_q[MDEPTH-1]) begin
                    p_d         = w_acc_next;
                    ovf_d       = sticky_q | w_bovf;
                    cnt_d       = w_cnt_inc;
                    out_valid_d = 1'b1;
                    sticky_d    = 1'b0;
                    count_d     = '0;
                end else begin
                    sticky_d = sticky_q | w_bovf;
                    count_d  = w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            in_vld_q    <= 1'b0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            in_c_q      <= '0;
            in_opm_q    <= '0;
            in_last_q   <= 1'b0;
            for (int i = 0; i < MDEPTH; i++) begin
                pr_vld_q[i]  <= 1'b0;
                pr_prod_q[i] <= '0;
                pr_c_q[i]    <= '0;
                pr_opm_q[i]  <= '0;
                pr_last_q[i] <= 1'b0;
            end
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            in_vld_q    <= in_vld_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            in_c_q      <= in_c_d;
            in_opm_q    <= in_opm_d;
            in_last_q   <= in_last_d;
            pr_vld_q    <= pr_vld_d;
            pr_prod_q   <= pr_prod_d;
            pr_c_q      <= pr_c_d;
            pr_opm_q    <= pr_opm_d;
            pr_last_q   <= pr_last_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;
    assign CNT       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mac_acc
// Description : Self-checking bench for dsp_mac_acc. A vector table and
//               hand-written sequences drive beats; expected chain results
//               are queued on acceptance and compared when the DUT hands
//               them off. A second instance runs with wrap-on-overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_acc;

    localparam longint c_pmax = 64'sh00007FFFFFFFFFFF;
    localparam longint c_pmin = -c_pmax - 64'sd1;

    typedef struct {
        logic [1:0]         opm;
        logic signed [17:0] a;
        logic signed [17:0] b;
        logic [47:0]        c;
        logic               last;
        logic [47:0]        p;
        logic               ovf;
        logic [15:0]        cnt;
    } vec_t;

    typedef struct {
        logic [47:0] p;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [17:0] A = '0;
    logic [17:0] B = '0;
    logic [47:0] C = '0;
    logic [1:0]  OPM = '0;
    logic        LAST = 1'b0;
    logic        rdy_set = 1'b1;
    logic        bp_en = 1'b0;
    logic        bp_rnd = 1'b1;
    logic        OUT_READY;

    logic        IN_READY, OUT_VALID, OVF;
    logic [47:0] P;
    logic [15:0] CNT;
    logic        IN_READY_w, OUT_VALID_w, OVF_w;
    logic [47:0] P_w;
    logic [15:0] CNT_w;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     g_wait = 0;
    longint m_acc = 0;
    logic   m_sticky = 1'b0;
    logic [15:0] m_cnt = '0;

    assign OUT_READY = bp_en ? bp_rnd : rdy_set;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1 bp_rnd = ($urandom_range(0, 2) != 0);
    end

    dsp_mac_acc #(.AW(18), .BW(18), .PW(48), .MDEPTH(2), .SAT_EN(1), .CW(16)) dut (
        .CLK(CLK), .RSTB(RSTB), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .C(C), .OPM(OPM), .LAST(LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .P(P), .OVF(OVF), .CNT(CNT)
    );

    dsp_mac_acc #(.AW(18), .BW(18), .PW(48), .MDEPTH(2), .SAT_EN(0), .CW(16)) dut_w (
        .CLK(CLK), .RSTB(RSTB), .IN_VALID(IN_VALID), .IN_READY(IN_READY_w),
        .A(A), .B(B), .C(C), .OPM(OPM), .LAST(LAST),
        .OUT_VALID(OUT_VALID_w), .OUT_READY(OUT_READY),
        .P(P_w), .OVF(OVF_w), .CNT(CNT_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model with saturation, in 64-bit integer arithmetic
    task automatic model(input vec_t v, output exp_t e);
        longint prod, ex, res;
        logic   bovf;
        logic [15:0] nc;
        prod = longint'(v.a) * longint'(v.b);
        case (v.opm)
            2'd0:    ex = prod;
            2'd1:    ex = m_acc + prod;
            2'd2:    ex = m_acc - prod;
            default: ex = longint'($signed(v.c)) + prod;
        endcase
        bovf = (ex > c_pmax) || (ex < c_pmin);
        if (!bovf)        res = ex;
        else if (ex < 0)  res = c_pmin;
        else              res = c_pmax;
        m_acc = res;
        nc = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        e.p = res[47:0];
        e.ovf = 1'b0;
        e.cnt = '0;
        if (v.last) begin
            e.ovf    = m_sticky | bovf;
            e.cnt    = nc;
            m_sticky = 1'b0;
            m_cnt    = '0;
        end else begin
            m_sticky = m_sticky | bovf;
            m_cnt    = nc;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge
    task automatic send(input vec_t v, input bit use_tab);
        exp_t e;
        int   n;
        n = 0;
        OPM = v.opm; A = v.a; B = v.b; C = v.c; LAST = v.last;
        IN_VALID = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (!IN_READY && n < 200);
        g_wait = n;
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted");
        end
        model(v, e);
        if (use_tab) begin
            e.p = v.p; e.ovf = v.ovf; e.cnt = v.cnt;
        end
        if (v.last) sb.push_back(e);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!OUT_VALID && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk(name, OUT_VALID, 1);
    endtask

    // Scoreboard: compare on each output handshake
    exp_t m_e;
    always @(negedge CLK) begin
        if (!RSTB && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out actual=P_0x%0h required=no_output", P);
            end else begin
                m_e = sb.pop_front();
                chk("out_p", P, m_e.p);
                chk("out_ovf", OVF, m_e.ovf);
                chk("out_cnt", CNT, m_e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    vec_t tab[11];
    vec_t v;
    logic seen;

    initial begin
        tab[0]  = '{2'b00, 18'sd3,    -18'sd4,  48'h0,            1'b1, 48'hFFFFFFFFFFF4, 1'b0, 16'd1};
        tab[1]  = '{2'b00, 18'sd2,    18'sd5,   48'h0,            1'b0, 48'h0,            1'b0, 16'd0};
        tab[2]  = '{2'b01, 18'sd3,    18'sd3,   48'h0,            1'b0, 48'h0,            1'b0, 16'd0};
        tab[3]  = '{2'b10, 18'sd1,    18'sd4,   48'h0,            1'b1, 48'd15,           1'b0, 16'd3};
        tab[4]  = '{2'b11, 18'sd1,    18'sd1,   48'h7FFFFFFFFFFF, 1'b1, 48'h7FFFFFFFFFFF, 1'b1, 16'd1};
        tab[5]  = '{2'b00, 18'h20000, 18'h20000, 48'h0,           1'b1, 48'h000400000000, 1'b0, 16'd1};
        tab[6]  = '{2'b01, 18'sd1000, -18'sd3,  48'h0,            1'b1, 48'h0003FFFFF448, 1'b0, 16'd1};
        tab[7]  = '{2'b11, 18'sd1,    18'sd1,   48'h800000000000, 1'b1, 48'h800000000001, 1'b0, 16'd1};
        tab[8]  = '{2'b10, 18'sd2,    18'sd1,   48'h0,            1'b0, 48'h0,            1'b0, 16'd0};
        tab[9]  = '{2'b01, 18'sd0,    18'sd5,   48'h0,            1'b1, 48'h800000000000, 1'b1, 16'd2};
        tab[10] = '{2'b01, 18'sd1,    18'sd1,   48'h0,            1'b1, 48'h800000000001, 1'b0, 16'd1};

        // Reset state
        #2;
        chk("rst_p", P, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_cnt", CNT, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        repeat (2) @(posedge CLK);
        #1 RSTB = 1'b0;

        // Table vectors, back to back with OUT_READY high
        for (int i = 0; i < 11; i++) begin
            send(tab[i], 1'b1);
            if (i >= 1 && i <= 3) chk("b2b_in_ready", g_wait, 1);
        end
        drain();
        chk("idle_out_valid", OUT_VALID, 0);

        // Overflow on C+product: saturate vs wrap instances side by side
        rdy_set = 1'b0;
        v = '{2'b11, 18'sd1, 18'sd1, 48'h7FFFFFFFFFFF, 1'b1, 48'h7FFFFFFFFFFF, 1'b1, 16'd1};
        send(v, 1'b1);
        wait_out_valid("sat_out_valid");
        chk("wrap_out_valid", OUT_VALID_w, 1);
        chk("wrap_p", P_w, 48'h800000000000);
        chk("wrap_ovf", OVF_w, 1);
        @(posedge CLK);
        #1 rdy_set = 1'b1;
        drain();

        // Two results in flight under backpressure
        rdy_set = 1'b0;
        v = '{2'b00, 18'sd5, 18'sd6, 48'h0, 1'b1, 48'd30, 1'b0, 16'd1};
        send(v, 1'b1);
        v = '{2'b01, 18'sd1, 18'sd1, 48'h0, 1'b1, 48'd31, 1'b0, 16'd1};
        send(v, 1'b1);
        wait_out_valid("bp_first_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("bp_hold_p", P, 48'd30);
            chk("bp_hold_valid", OUT_VALID, 1);
            chk("bp_in_ready", IN_READY, 0);
            chk("bp_hold_cnt", CNT, 1);
        end
        @(posedge CLK);
        #1 rdy_set = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("bp_second_valid", OUT_VALID, 1);
        chk("bp_second_p", P, 48'd31);
        drain();

        // Random beats with random backpressure and bubbles
        bp_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            v.opm  = 2'($urandom_range(0, 3));
            v.a    = 18'($urandom);
            v.b    = 18'($urandom);
            v.c    = 48'({$urandom, $urandom});
            v.last = (i == 59) || ($urandom_range(0, 3) == 0);
            v.p = '0; v.ovf = 1'b0; v.cnt = '0;
            send(v, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        drain();
        bp_en = 1'b0;
        drain();

        // Reset with three beats in flight
        v = '{2'b00, 18'sd1, 18'sd1, 48'h0, 1'b0, 48'h0, 1'b0, 16'd0};
        send(v, 1'b0);
        v.opm = 2'b01;
        send(v, 1'b0);
        v.last = 1'b1;
        send(v, 1'b0);
        #2 RSTB = 1'b1;
        #1;
        chk("arst_p", P, 0);
        chk("arst_ovf", OVF, 0);
        chk("arst_cnt", CNT, 0);
        chk("arst_out_valid", OUT_VALID, 0);
        chk("arst_in_ready", IN_READY, 1);
        @(posedge CLK);
        @(negedge CLK);
        RSTB = 1'b0;
        sb.delete();
        m_acc = 0; m_sticky = 1'b0; m_cnt = '0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        chk("post_rst_quiet", seen, 0);
        @(posedge CLK);
        #1;
        v = '{2'b01, 18'sd2, 18'sd2, 48'h0, 1'b1, 48'd4, 1'b0, 16'd1};
        send(v, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_acc.md
DSP_MAC_ACC -- requirements
Module: dsp_mac_acc

Interface
REQ-001 SHALL have parameter AW, default 18: signed A operand width (2..32).
REQ-002 SHALL have parameter BW, default 18: signed B operand width (2..32).
REQ-003 SHALL have parameter PW, default 48: signed accumulator/C/P width; PW >= AW+BW+1.
REQ-004 SHALL have parameter MDEPTH, default 2: product register stages (1..4).
REQ-005 SHALL have parameter SAT_EN, default 1: 1 = saturate on overflow, 0 = wrap.
REQ-006 SHALL have parameter CW, default 16: beat-count width.
REQ-007 SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-008 SHALL have port RSTB  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port IN_VALID  in  1  input beat valid.
REQ-010 SHALL have port IN_READY  out  1  input beat accepted when IN_VALID & IN_READY.
REQ-011 SHALL have port A  in  AW  signed multiplicand.
REQ-012 SHALL have port B  in  BW  signed multiplier.
REQ-013 SHALL have port C  in  PW  signed addend, used only by OPM=11.
REQ-014 SHALL have port OPM  in  2  operation: 00 load, 01 add-acc, 10 sub-acc, 11 C-plus-product.
REQ-015 SHALL have port LAST  in  1  final beat of chain; produces an output beat.
REQ-016 SHALL have port OUT_VALID  out  1  result valid.
REQ-017 SHALL have port OUT_READY  in  1  downstream accepts when OUT_VALID & OUT_READY.
REQ-018 SHALL have port P  out  PW  signed result.
REQ-019 SHALL have port OVF  out  1  overflow occurred anywhere in the emitted chain.
REQ-020 SHALL have port CNT  out  CW  number of beats in the emitted chain.

Function
REQ-021 SHALL form PROD = A*B as a signed product, sign-extended to PW.
REQ-022 SHALL compute ACC_NEXT per OPM: 00 PROD; 01 ACC+PROD; 10 ACC-PROD; 11 C+PROD.
REQ-023 SHALL flag beat overflow when the PW+1-bit exact ACC_NEXT does not fit in PW signed bits.
REQ-024 SHALL, on overflow, clamp to 2^(PW-1)-1 or -2^(PW-1) by sign of the exact result when SAT_EN=1, else keep the low PW bits.
REQ-025 SHALL pipeline as: input register (edge t) -> MDEPTH product registers -> accumulate/output register; A, B, C, OPM, LAST and valid travel in lockstep.
REQ-026 SHALL give latency MDEPTH+1 edges: beat accepted at edge t updates ACC at edge t+MDEPTH+1; with LAST=1, OUT_VALID is high in the cycle after that edge.
REQ-027 SHALL update ACC, the sticky overflow flag and the beat counter only for valid stages; bubbles leave all state unchanged.
REQ-028 SHALL define ADV = !OUT_VALID | OUT_READY; IN_READY = ADV; when ADV=0 the whole pipeline, ACC and outputs hold.
REQ-029 SHALL sustain one beat per cycle when OUT_READY=1.
REQ-030 SHALL keep P, OVF and CNT stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 SHALL, on each LAST beat commit: P=ACC_NEXT, OVF=sticky|beat overflow, CNT=count+1 (saturating at 2^CW-1), OUT_VALID=1; then clear sticky and count.
REQ-032 SHALL clear OUT_VALID on an output handshake unless a new LAST beat commits on the same edge.
REQ-033 SHALL, on a non-LAST commit, OR the beat overflow into sticky and increment count (saturating at 2^CW-1).
REQ-034 SHALL retain ACC after a LAST commit; a following OPM=01/10 beat continues from it.
REQ-035 SHALL use no combinational path from IN_VALID to IN_READY.

Reset
REQ-036 SHALL, while RSTB=1, immediately force ACC, sticky, count, all stage valids, OUT_VALID, P, OVF and CNT to 0; IN_READY=1.
REQ-037 SHALL discard beats in flight at reset; after release, no OUT_VALID until a new LAST beat has passed the full latency.

Verification (AW=BW=18, PW=48, MDEPTH=2, SAT_EN=1 unless stated)
REQ-038 SHALL pass: OPM=00, A=3, B=-4, LAST=1 accepted at edge 0, OUT_READY=1 -> OUT_VALID after edge 3, P=0xFFFFFFFFFFF4, CNT=1, OVF=0.
REQ-039 SHALL pass: back-to-back beats (00,2,5), (01,3,3), (10,1,4,LAST) -> single output P=15, CNT=3, OVF=0; IN_READY stays 1.
REQ-040 SHALL pass: two LAST beats in flight, OUT_READY=0 for 5 cycles -> first result held stable, IN_READY=0; second result appears on the cycle after the first handshake, none lost.
REQ-041 SHALL pass: OPM=11, C=0x7FFFFFFFFFFF, A=1, B=1, LAST -> P=0x7FFFFFFFFFFF, OVF=1; with SAT_EN=0 -> P=0x800000000000, OVF=1.
REQ-042 SHALL pass: OPM=00, A=B=-131072, LAST -> P=0x000400000000 (2^34), OVF=0.
REQ-043 SHALL pass: RSTB pulsed mid-chain with 3 beats in flight -> all outputs 0 asynchronously, no spurious OUT_VALID; then (01,2,2,LAST) -> P=4, CNT=1.
